// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl: synchronize and debounce N buttons, queue presses as pending events
// and issue them round-robin on a valid/ready port.
module btn_event_ctrl #(
    parameter int N_BTN = 4,
    parameter int TICK_DIV = 100000,
    parameter int STABLE_CNT = 4,
    localparam int ID_W = $clog2(N_BTN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic             ev_valid,
    output logic [ID_W-1:0]  ev_id,
    input  logic             ev_ready,
    output logic             ev_overrun
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int CW = STABLE_CNT > 1 ? $clog2(STABLE_CNT) : 1;

    logic [N_BTN-1:0] sync1_q, sync_q, level_q, level_d, pending_q, pending_d, press, clr;
    logic [CW-1:0]    cnt_q [N_BTN];
    logic [CW-1:0]    cnt_d [N_BTN];
    logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
    logic [ID_W-1:0]  id_q, id_d, last_q, last_d, grant, idx;
    logic             valid_q, valid_d, overrun_q, overrun_d, tick, load, found;

    always_comb begin
        tick = tick_cnt_q == TW'(TICK_DIV - 1);
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        level_d = level_q;
        cnt_d = cnt_q;
        press = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (tick && sync_q[i] == level_q[i]) cnt_d[i] = '0;
            else if (tick && cnt_q[i] == CW'(STABLE_CNT - 1)) begin
                level_d[i] = sync_q[i];
                cnt_d[i] = '0;
                press[i] = sync_q[i];
            end else if (tick) cnt_d[i] = cnt_q[i] + 1'b1;
        end
        // first pending index strictly after the last grant, wrapping
        grant = last_q;
        found = 1'b0;
        idx = '0;
        for (int k = 1; k <= N_BTN; k++) begin
            idx = ID_W'((int'(last_q) + k) % N_BTN);
            if (!found && pending_q[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
        load = !valid_q || ev_ready;
        clr = (load && found) ? N_BTN'(1) << grant : '0;
        pending_d = (pending_q & ~clr) | press;
        overrun_d = |(press & pending_q & ~clr);
        valid_d = load ? found : valid_q;
        id_d = (load && found) ? grant : id_q;
        last_d = (load && found) ? grant : last_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync_q <= '0;
            tick_cnt_q <= '0;
            cnt_q <= '{default: '0};
            level_q <= '0;
            pending_q <= '0;
            valid_q <= 1'b0;
            id_q <= '0;
            last_q <= ID_W'(N_BTN - 1);
            overrun_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync_q <= sync1_q;
            tick_cnt_q <= tick_cnt_d;
            cnt_q <= cnt_d;
            level_q <= level_d;
            pending_q <= pending_d;
            valid_q <= valid_d;
            id_q <= id_d;
            last_q <= last_d;
            overrun_q <= overrun_d;
        end
    end

    assign btn_level = level_q;
    assign ev_valid = valid_q;
    assign ev_id = id_q;
    assign ev_overrun = overrun_q;
endmodule

// File: doc/btn_event_ctrl.md
# btn_event_ctrl

Multi-button input controller that sits between the board pushbuttons and the checksum control FSM. It synchronizes and debounces N raw buttons using a shared sample-tick prescaler. Each clean press becomes a pending event, and a round-robin arbiter presents pending events one at a time on a valid/ready port. Downstream logic therefore receives exactly one event per physical press, never a bounce train, and never loses a simultaneous press.

## Interface
- N_BTN, 4, number of buttons (≥2); ID_W = clog2(N_BTN)
- TICK_DIV, 100000, clock cycles per debounce sample tick (≥2; 1 kHz at 100 MHz)
- STABLE_CNT, 4, consecutive disagreeing ticks required to change a debounced level (≥1)

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- btn_raw  in  N_BTN  raw asynchronous button inputs, 1 = pressed
- btn_level  out  N_BTN  debounced button levels
- ev_valid  out  1  event available
- ev_id  out  ID_W  index of pressed button, valid while ev_valid
- ev_ready  in  1  downstream accepts event
- ev_overrun  out  1  one-cycle pulse: press arrived while same button already pending

## Operation
- Synchronizer: two flops per bit, sync = second stage; reset 0.
- Prescaler: tick_cnt counts 0..TICK_DIV-1 and wraps to 0. tick = (tick_cnt == TICK_DIV-1), high one cycle in every TICK_DIV cycles. tick_cnt resets to 0.
- Debounce, per bit i, evaluated only on tick cycles:
  - sync[i] == btn_level[i]: cnt[i] ← 0.
  - Mismatch and cnt[i] < STABLE_CNT-1: cnt[i] ← cnt[i]+1.
  - Mismatch and cnt[i] == STABLE_CNT-1: btn_level[i] ← sync[i], cnt[i] ← 0.
- press[i]: combinational; true on the tick that changes btn_level[i] from 0 to 1. Releases generate nothing.
- pending[i] update:
  - Set by press[i].
  - Cleared when i is loaded into the output register.
  - If press and clear happen on the same edge, pending stays 1.
- Overrun: press[i] with pending[i]=1 that is not being cleared this edge. Result: ev_overrun=1 for one cycle and pending unchanged, so the event is counted once. Several bits overrunning in the same cycle still give one pulse.
- Output register loads when (!ev_valid || ev_ready):
  - If any pending bit is set: ev_valid←1, ev_id←first set index searching upward from last_grant+1 mod N_BTN, last_grant←ev_id, and that pending bit clears.
  - Otherwise ev_valid←0.
- Handshake:
  - While ev_valid && !ev_ready, ev_valid and ev_id hold stable.
  - A transfer occurs on any cycle with ev_valid && ev_ready.
  - ev_ready while !ev_valid is ignored.
- Reset values:
  - btn_level=0, ev_valid=0, ev_id=0, ev_overrun=0.
  - pending=0, cnt=0, sync flops=0.
  - last_grant=N_BTN-1, so index 0 has first priority.
- Reset asserted mid-operation discards all pending and in-flight events. There is no event after release unless a new debounced press occurs.

## Timing
- Raw change to btn_level: 2 sync cycles, then STABLE_CNT consecutive mismatching ticks, i.e. ≤ 2 + STABLE_CNT·TICK_DIV cycles.
- pending set on the same edge as btn_level rises.
- ev_valid rises one edge after that, if the output register is free.
- Back-to-back: on a transfer edge with other bits pending, the next event loads on that same edge, giving one event per cycle under continuous ev_ready.
- Any bounce shorter than STABLE_CNT ticks resets cnt and produces no level change.
- Simultaneous presses on several buttons on one tick are all set pending. They are issued in round-robin order, one per accepted handshake.

## Test plan
All scenarios use N_BTN=4, TICK_DIV=4, STABLE_CNT=3.
- Reset: assert reset mid-count with btn_raw=4'b1111 -> all outputs 0 immediately (asynchronous); after release, first event requires a full 3-tick debounce.
- Bounce: btn_raw[0] toggles every half cycle for 200 ns, then held 1 -> btn_level[0] rises once ≤ 2+12 cycles after the last edge; exactly one event ev_id=0; no event on a later release.
- Glitch rejection: btn_raw[1] high for 2 ticks, then low -> btn_level[1] stays 0; no event.
- Simultaneous: btn_raw=4'b1011 on one tick, held, ev_ready=1 -> ev_id sequence 0,1,3 on three consecutive cycles; then ev_valid=0.
- Backpressure and fairness: ev_ready=0, buttons 2 then 0 pressed -> ev_id=2 held stable; then ev_ready=1 -> 2 then 0. After that, presses on 0 and 3 together -> order 3,0, since last_grant=0.
- Overrun: ev_ready=0, ev_id=1 presented, pending[1]=0 -> release and re-press button 1 twice. First re-press sets pending[1], no pulse. Second re-press gives ev_overrun pulse of 1 cycle. Then ev_ready=1 -> exactly two ev_id=1 events.
